// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with single-cycle logic/add/slt ops
// and iterative shift-add MUL and one-bit-per-cycle SLL/SRL.
module alu_seq #(
    parameter int WIDTH = 24,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             ainvert_i,
    input  logic             binvert_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_out_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        SHIFT_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH:0]   sum;
    logic             ovf_c;
    logic [SW-1:0]    shamt;
    logic             sh_big;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH-1:0] sh_nxt;
    logic             wr;
    logic [WIDTH-1:0] res_w;
    logic             cout_w, ovf_w;

    always_comb begin
        ma      = ainvert_i ? ~a_i : a_i;
        mb      = binvert_i ? ~b_i : b_i;
        sum     = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, cin_i};
        ovf_c   = (ma[WIDTH-1] == mb[WIDTH-1]) &&
                  (sum[WIDTH-1] != ma[WIDTH-1]);
        shamt   = b_i[SW-1:0];
        sh_big  = int'(shamt) >= WIDTH;
        mul_add = acc_q + (opb_q[0] ? opa_q : '0);
        sh_nxt  = dir_q ? (opa_q >> 1) : (opa_q << 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        dir_d   = dir_q;
        wr      = 1'b0;
        res_w   = '0;
        cout_w  = 1'b0;
        ovf_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    unique case (op_i)
                        3'b000: begin
                            wr    = 1'b1;
                            res_w = ma & mb;
                        end
                        3'b001: begin
                            wr    = 1'b1;
                            res_w = ma | mb;
                        end
                        3'b010: begin
                            wr     = 1'b1;
                            res_w  = sum[WIDTH-1:0];
                            cout_w = sum[WIDTH];
                            ovf_w  = ovf_c;
                        end
                        3'b011: begin
                            wr     = 1'b1;
                            res_w  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_c};
                            cout_w = sum[WIDTH];
                            ovf_w  = ovf_c;
                        end
                        3'b100: begin
                            opa_d   = a_i;
                            opb_d   = b_i;
                            acc_d   = '0;
                            cnt_d   = CW'(WIDTH);
                            state_d = MUL_RUN;
                        end
                        3'b101, 3'b110: begin
                            // Trivial shift amounts finish in one cycle
                            if (shamt == '0) begin
                                wr    = 1'b1;
                                res_w = a_i;
                            end else if (sh_big) begin
                                wr    = 1'b1;
                                res_w = '0;
                            end else begin
                                opa_d   = a_i;
                                dir_d   = op_i[1];
                                cnt_d   = CW'(shamt);
                                state_d = SHIFT_RUN;
                            end
                        end
                        default: begin
                            wr    = 1'b1;
                            res_w = '0;
                        end
                    endcase
                end
            end
            MUL_RUN: begin
                acc_d = mul_add;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    wr      = 1'b1;
                    res_w   = mul_add;
                    state_d = IDLE;
                end
            end
            SHIFT_RUN: begin
                opa_d = sh_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    wr      = 1'b1;
                    res_w   = sh_nxt;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = wr;
        if (wr) begin
            result_d = res_w;
            cout_d   = cout_w;
            ovf_d    = ovf_w;
            zero_d   = (res_w == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign result_o    = result_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;
    assign zero_o      = zero_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU that generalises the CPU's 1-bit ALU slice to a full WIDTH-bit datapath. Single-cycle AND/OR/ADD/SLT are kept with operand-invert controls; iterative MUL (shift-add) and SLL/SRL (one bit per cycle) are added. A Start/Busy/Done handshake lets the control unit stall the single-cycle CPU while an iterative op runs. Results and flags are registered and held until the next accepted operation.

## Interface
- WIDTH, 24, datapath width in bits (≥ 2).
- SW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

- Clock  in  1  rising-edge clock, sole clock domain.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL, 101 SLL, 110 SRL, 111 reserved.
- AInvert  in  1  use ~A instead of A (AND/OR/ADD/SLT only).
- BInvert  in  1  use ~B instead of B (AND/OR/ADD/SLT only).
- CIN  in  1  adder carry-in (ADD/SLT only).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; shift amount = B[SW-1:0] for SLL/SRL.
- Result  out  WIDTH  registered result.
- CarryOut  out  1  adder carry out (ADD/SLT), else 0.
- Overflow  out  1  signed overflow of mA+mB+CIN (ADD/SLT), else 0.
- Zero  out  1  Result == 0.
- Busy  out  1  iterative op in progress.
- Done  out  1  one-cycle pulse: Result/flags updated.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- mA = AInvert ? ~A : A; mB = BInvert ? ~B : B; S = mA + mB + CIN in WIDTH+1 bits.
- AND: mA & mB. OR: mA | mB. ADD: S[WIDTH-1:0], CarryOut = S[WIDTH], Overflow = (mA[W-1]==mB[W-1]) && (S[W-1]!=mA[W-1]).
- SLT: Result = {0…, S[W-1] ^ Overflow}; CarryOut/Overflow as ADD. With BInvert=1, CIN=1 gives signed A<B.
- MUL: unsigned A×B, low WIDTH bits kept; WIDTH iterations, one bit of B per cycle (LSB first). Invert controls ignored; CarryOut=Overflow=0.
- SLL/SRL: logical shift of A by n = B[SW-1:0], one position per cycle, zero fill. n=0 → Result=A. n ≥ WIDTH → Result=0, completes as single-cycle op.
- Reserved Op 111: Result=0, single-cycle, flags 0, Zero=1.
- States: IDLE, MUL_RUN, SHIFT_RUN.
  - IDLE + Start + single-cycle op (incl. shift n=0 or n≥WIDTH): write Result/flags, Done=1 next cycle, stay IDLE.
  - IDLE + Start + MUL: latch A, B, clear accumulator, counter=WIDTH → MUL_RUN.
  - IDLE + Start + shift 1≤n<WIDTH: latch A, counter=n → SHIFT_RUN.
  - RUN states: one step per edge, counter decrements; on the step bringing counter to 0, write Result/flags → IDLE, Done=1.
- Start while Busy=1: ignored, no effect on operation or latched operands.
- A/B/Op changes during RUN: no effect (operands latched).

## Timing
- Reset values: Result=0, CarryOut=0, Overflow=0, Zero=1, Busy=0, Done=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts it: next cycle all outputs at reset values; no Done for aborted op.
- Latency L = edges from the one sampling Start through the one after which Done=1: single-cycle ops 1, MUL WIDTH+1, shift n+1.
- Busy=1 for exactly L−1 cycles, starting the cycle after Start is sampled; Busy falls in the same cycle Done rises.
- Done high exactly one cycle per accepted op. Start asserted while Done=1 is accepted (Busy=0) → back-to-back ops, no bubble.
- Result/flags change only on the completion edge or reset; held stable otherwise, including during Busy.
- Zero is registered with Result (never combinational from a stale value).

## Test plan
- Reset then ADD A=0x7FFFFF, B=0x000001, CIN=0 → next cycle Result=0x800000, Overflow=1, CarryOut=0, Zero=0, Done one cycle.
- SUB via ADD, BInvert=1, CIN=1, A=B=0x000005 → Result=0, Zero=1, CarryOut=1; SLT same controls A=0xFFFFFF, B=0x000001 → Result=0x000001.
- MUL A=0x001234, B=0x000100 → Busy high 24 cycles, Done at L=25, Result=0x123400; Start pulsed mid-run ignored, Result unchanged.
- SLL A=0x000001, B=23 → Done at L=24, Result=0x800000; SRL B=24 → L=1, Result=0; SLL B=0 → L=1, Result=A.
- Back-to-back: Start held high through Done of MUL → OR op accepted that cycle, its Done the following cycle.
- Reset at cycle 10 of MUL → Busy=0, Result=0, Zero=1, no Done; next Start ADD 2+3 → Result=5 at L=1.
